// File: rtl/flag_chk_pkg.sv
// rtl/flag_chk_pkg.sv - shared state and error-code definitions for the flag order checker
package flag_chk_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    WAIT0    = 3'd2,
    WAIT1    = 3'd3,
    WAIT_FIN = 3'd4
  } state_e;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_B_NOT_LOW  = 2'd1;
  localparam logic [1:0] ERR_B_NOT_HIGH = 2'd2;

endpackage

// File: rtl/delay_down_counter.sv
// rtl/delay_down_counter.sv - loadable down-counter with a zero flag
module delay_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; decrement holds at zero so an idle counter never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/flag_order_checker.sv
// rtl/flag_order_checker.sv - clock-counted checker that flag_b goes 0 then 1 after a flag_a change
module flag_order_checker
  import flag_chk_pkg::*;
#(
  parameter int CHECK0_DLY = 1,
  parameter int CHECK1_DLY = 2,
  parameter int FINISH_DLY = 10,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       flag_a,
  input  logic       flag_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic [1:0] err_code
);

  // Counter reload values: a delay of N cycles expires N edges after the load
  localparam logic [CNT_W-1:0] LD_CHECK0 = CNT_W'(CHECK0_DLY - 1);
  localparam logic [CNT_W-1:0] LD_CHECK1 = CNT_W'(CHECK1_DLY - 1);
  localparam logic [CNT_W-1:0] LD_FINISH = CNT_W'(FINISH_DLY - 1);

  state_e           state, state_d;
  logic             flag_a_q, flag_a_q_d;
  logic             done_d, pass_d, fail_d;
  logic [1:0]       err_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  assign busy = (state == WAIT0) || (state == WAIT1) || (state == WAIT_FIN);

  delay_down_counter #(
    .CNT_W(CNT_W)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .dec     (busy),
    .load_val(cnt_load_val),
    .zero    (cnt_zero)
  );

  // Next-state, counter control and result updates; an X/Z flag_b fails both equality tests
  always_comb begin
    state_d      = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    done_d       = 1'b0;
    pass_d       = pass;
    fail_d       = fail;
    err_d        = err_code;
    flag_a_q_d   = flag_a_q;
    case (state)
      ARM: state_d = IDLE;
      IDLE: begin
        if (enable && (flag_a != flag_a_q)) begin
          pass_d       = 1'b0;
          fail_d       = 1'b0;
          err_d        = ERR_NONE;
          cnt_load     = 1'b1;
          cnt_load_val = LD_CHECK0;
          state_d      = WAIT0;
        end
      end
      WAIT0: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          if (flag_b == 1'b0) begin
            cnt_load     = 1'b1;
            cnt_load_val = LD_CHECK1;
            state_d      = WAIT1;
          end else begin
            fail_d  = 1'b1;
            err_d   = ERR_B_NOT_LOW;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT1: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          if (flag_b == 1'b1) begin
            cnt_load     = 1'b1;
            cnt_load_val = LD_FINISH;
            state_d      = WAIT_FIN;
          end else begin
            fail_d  = 1'b1;
            err_d   = ERR_B_NOT_HIGH;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_FIN: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          pass_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Track flag_a outside a run, and resample on the way back so mid-run edges never retrigger
    if ((state == ARM) || (state == IDLE) || (state_d == IDLE)) begin
      flag_a_q_d = flag_a;
    end
  end

  // State, edge-detect reference and sticky result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARM;
      flag_a_q <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      state    <= state_d;
      flag_a_q <= flag_a_q_d;
      done     <= done_d;
      pass     <= pass_d;
      fail     <= fail_d;
      err_code <= err_d;
    end
  end

endmodule

// File: tb/tb_flag_order_checker.sv
// tb/tb_flag_order_checker.sv - self-checking bench with an offset-based reference model
module tb_flag_order_checker;

  localparam int C0 = 1;
  localparam int C1 = 2;
  localparam int FD = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       flag_a = 1'b0;
  logic       flag_b = 1'b0;
  logic       busy, done, pass, fail;
  logic [1:0] err_code;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  // Reference model: a run is described only by the edge at which it was triggered
  bit         m_arm = 1'b1;
  bit         m_active = 1'b0;
  bit         m_done = 1'b0;
  bit         m_pass = 1'b0;
  bit         m_fail = 1'b0;
  logic [1:0] m_err = 2'd0;
  logic       m_prev_a = 1'b0;
  int         m_t = 0;
  int         m_rel = 0;
  logic [5:0] act_v, exp_v;

  always #5 clk = ~clk;

  flag_order_checker #(
    .CHECK0_DLY(C0),
    .CHECK1_DLY(C1),
    .FINISH_DLY(FD),
    .CNT_W     (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .flag_a  (flag_a),
    .flag_b  (flag_b),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .fail    (fail),
    .err_code(err_code)
  );

  // Model step at each active edge
  always @(posedge clk) begin
    if (!rst_n) begin
      edge_n = 0; m_arm = 1; m_active = 0; m_done = 0;
      m_pass = 0; m_fail = 0; m_err = 2'd0; m_prev_a = 1'b0; m_t = 0;
    end else begin
      edge_n = edge_n + 1;
      m_done = 0;
      if (m_arm) begin
        m_arm = 0;
        m_prev_a = flag_a;
      end else if (!m_active) begin
        if (enable && (flag_a !== m_prev_a)) begin
          m_active = 1; m_t = edge_n; m_pass = 0; m_fail = 0; m_err = 2'd0;
        end
        m_prev_a = flag_a;
      end else begin
        m_rel = edge_n - m_t;
        if (!enable) begin
          m_active = 0; m_prev_a = flag_a;
        end else if (m_rel == C0 && flag_b !== 1'b0) begin
          m_fail = 1; m_err = 2'd1; m_done = 1; m_active = 0; m_prev_a = flag_a;
        end else if (m_rel == C0 + C1 && flag_b !== 1'b1) begin
          m_fail = 1; m_err = 2'd2; m_done = 1; m_active = 0; m_prev_a = flag_a;
        end else if (m_rel == C0 + C1 + FD) begin
          m_pass = 1; m_done = 1; m_active = 0; m_prev_a = flag_a;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    act_v = {busy, done, pass, fail, err_code};
    exp_v = rst_n ? {m_active, m_done, m_pass, m_fail, m_err} : 6'b0;
    vectors = vectors + 1;
    if (act_v !== exp_v) begin
      miscompares = miscompares + 1;
      $display("FAIL cycle_compare edge %0d: busy,done,pass,fail,err got %b required %b",
               edge_n, act_v, exp_v);
    end
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic after_edge(input int k);
    int guard;
    guard = 0;
    while (edge_n < k && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (edge_n != k) begin
      vectors = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL wait_edge: reached edge %0d required %0d", edge_n, k);
    end
  endtask

  task automatic before_edge(input int k);
    after_edge(k - 1);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0; enable = 1'b1; flag_b = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Nominal run
    do_reset();
    after_edge(1);
    chk("reset_busy", busy, 0); chk("reset_pass", pass, 0); chk("reset_err", err_code, 0);
    before_edge(10); flag_a = ~flag_a;
    after_edge(10); chk("nom_busy_e10", busy, 1);
    before_edge(12); flag_b = 1'b1;
    after_edge(22); chk("nom_done_e22", done, 0);
    after_edge(23); chk("nom_done_e23", done, 1); chk("nom_pass_e23", pass, 1);
    chk("nom_err_e23", err_code, 0); chk("nom_busy_e23", busy, 0);
    after_edge(24); chk("nom_done_e24", done, 0); chk("nom_pass_e24", pass, 1);

    // flag_b high too early
    do_reset();
    before_edge(10); flag_a = ~flag_a;
    before_edge(11); flag_b = 1'b1;
    after_edge(11); chk("early_done", done, 1); chk("early_fail", fail, 1);
    chk("early_err", err_code, 1); chk("early_busy", busy, 0);
    after_edge(12); chk("early_done_e12", done, 0); chk("early_fail_e12", fail, 1);

    // flag_b never rises
    do_reset();
    before_edge(10); flag_a = ~flag_a;
    after_edge(12); chk("late_busy_e12", busy, 1); chk("late_done_e12", done, 0);
    after_edge(13); chk("late_done", done, 1); chk("late_fail", fail, 1);
    chk("late_err", err_code, 2);

    // Mid-run toggle ignored, then a second run
    do_reset();
    before_edge(10); flag_a = ~flag_a;
    before_edge(12); flag_a = ~flag_a; flag_b = 1'b1;
    after_edge(23); chk("retrig_pass", pass, 1); chk("retrig_done", done, 1);
    after_edge(24); chk("retrig_no_restart", busy, 0);
    before_edge(30); flag_a = ~flag_a;
    after_edge(30); chk("rerun_pass_clear", pass, 0); chk("rerun_busy", busy, 1);
    #1; flag_b = 1'b0;
    after_edge(31); chk("rerun_check0", fail, 0);
    #1; flag_b = 1'b1;
    after_edge(42); chk("rerun_done_e42", done, 0);
    after_edge(43); chk("rerun_done_e43", done, 1); chk("rerun_pass_e43", pass, 1);

    // Asynchronous reset in WAIT_FIN, then ARM-cycle change ignored
    do_reset();
    before_edge(10); flag_a = ~flag_a;
    before_edge(12); flag_b = 1'b1;
    after_edge(14);
    @(posedge clk);
    #2; rst_n = 1'b0;
    #1; chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0); chk("rst_err", err_code, 0);
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b1; flag_a = ~flag_a;
    after_edge(2); chk("arm_no_trigger", busy, 0);
    #1; flag_a = ~flag_a;
    after_edge(3); chk("post_arm_trigger", busy, 1);

    // Abort by enable
    do_reset();
    before_edge(10); flag_a = ~flag_a;
    before_edge(12); enable = 1'b0;
    after_edge(12); chk("abort_busy", busy, 0); chk("abort_done", done, 0);
    chk("abort_pass", pass, 0); chk("abort_fail", fail, 0);
    after_edge(14); chk("abort_no_done", done, 0);
    #1; enable = 1'b1;

    // Randomized traffic, checked cycle by cycle against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      enable = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 7) == 0) flag_a = ~flag_a;
      flag_b = 1'($urandom_range(0, 1));
      rst_n  = ($urandom_range(0, 599) != 0);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flag_order_checker.md
# flag_order_checker

Cycle-based consumer that sits directly downstream of the flag sequencer, which drives `flag_a`/`flag_b` from `clk`. It watches `flag_a` for any change. On a change it samples `flag_b` at two fixed cycle offsets and requires `flag_b` to be 0, then 1. After a settle interval it reports pass/fail with a `done` pulse. It replaces free-running `#`-delay checkers with a synthesizable, clock-counted equivalent for timing regressions.

## Interface
- `CHECK0_DLY`, default 1: cycles from trigger edge to the first check (`flag_b` must be 0); ≥1.
- `CHECK1_DLY`, default 2: cycles from the first check to the second check (`flag_b` must be 1); ≥1.
- `FINISH_DLY`, default 10: cycles from the second check to the pass report; ≥1.
- `CNT_W`, default 8: delay counter width. Every `*_DLY` must be ≤ 2^CNT_W.
- `clk`  in  1: single clock; all state updates on posedge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: arms triggering; deasserting it aborts a run in progress.
- `flag_a`  in  1: trigger flag; any change (either polarity) starts a run.
- `flag_b`  in  1: flag under check.
- `busy`  out  1: high while a run is in progress.
- `done`  out  1: one-cycle pulse at the end of a run (pass or fail).
- `pass`  out  1: sticky; set when a run completes cleanly.
- `fail`  out  1: sticky; set when a check fails.
- `err_code`  out  2: 0 = none, 1 = `flag_b` not 0 at check0, 2 = `flag_b` not 1 at check1.

## Operation
- States: `IDLE`, `ARM`, `WAIT0`, `WAIT1`, `WAIT_FIN`.
- After reset the FSM is in `ARM`. `ARM` lasts one cycle, captures `flag_a` into `flag_a_q`, and moves to `IDLE`. No trigger is possible during `ARM`.
- `IDLE` updates `flag_a_q` every cycle.
  - Trigger condition: `enable && flag_a != flag_a_q`.
  - On trigger: clear `pass`, `fail` and `err_code`; load the counter with `CHECK0_DLY-1`; go to `WAIT0`.
- `WAIT0`: counter decrements each cycle.
  - At zero, `flag_b==0`: load `CHECK1_DLY-1` and go to `WAIT1`.
  - At zero, otherwise: `fail=1`, `err_code=1`, pulse `done`, go to `IDLE`.
- `WAIT1`: same rule with `flag_b==1`.
  - At zero, pass: load `FINISH_DLY-1` and go to `WAIT_FIN`.
  - At zero, fail: `err_code=2`.
- `WAIT_FIN`: at zero, `pass=1`, pulse `done`, go to `IDLE`.
- Changes on `flag_a` while `busy` are ignored. `flag_a_q` is resampled on re-entry to `IDLE`, so an edge that occurred during the run does not retrigger.
- Deasserting `enable` in any WAIT state aborts to `IDLE` on the next edge. There is no `done` pulse, and `pass`, `fail` and `err_code` keep their prior values.
- Checks are 4-state in simulation: X or Z on `flag_b` at a check counts as a failure.
- `busy` is 1 exactly in `WAIT0`, `WAIT1` and `WAIT_FIN`.

## Timing
- Reset values: `busy=0`, `done=0`, `pass=0`, `fail=0`, `err_code=0`, state `ARM`, counter 0, `flag_a_q=0`.
- Reset asserted mid-run forces these values immediately, without waiting for a clock edge.
- Offsets are counted from trigger edge k, the edge at which the change is seen:
  - check0 samples `flag_b` at edge k+CHECK0_DLY;
  - check1 samples at edge k+CHECK0_DLY+CHECK1_DLY;
  - `done`/`pass` are registered at edge k+CHECK0_DLY+CHECK1_DLY+FINISH_DLY.
- `done` is high for exactly one cycle. A new trigger is accepted no earlier than the edge after `done`.
- `pass`/`fail` change only at a trigger edge (clear) or at a `done` edge (set).

## Structure
- Package `flag_chk_pkg` holds:
  - the `state_e` enum;
  - the `err_code` constants `ERR_NONE`, `ERR_B_NOT_LOW`, `ERR_B_NOT_HIGH`.
- Sub-module `delay_down_counter`: `CNT_W`-bit loadable down-counter with `load`, `load_val` and a `zero` flag, reset to 0.
- The top level holds the FSM, edge detect and sticky result registers.

## Test plan
All scenarios use default parameters.
- Nominal: `flag_a` 0→1 at edge 10, `flag_b`=0 until it is set to 1 at edge 12 → check0 at edge 11 passes, check1 at edge 13 passes, `done`+`pass` at edge 23, `err_code`=0.
- Early `flag_b`: `flag_b`=1 at edge 11 → `fail`=1, `err_code`=1, `done` at edge 11, `busy` low from edge 11.
- Late `flag_b`: `flag_b` stays 0 → `fail`=1, `err_code`=2, `done` at edge 13.
- Retrigger and re-run:
  - extra `flag_a` toggle at edge 12 is ignored; `pass` at edge 23;
  - a toggle at edge 30 clears `pass` at edge 30 and produces a second `done` at edge 43.
- Reset mid-run: `rst_n` low at edge 15 (in `WAIT_FIN`) → all outputs 0 immediately.
  - After release, a `flag_a` change in the `ARM` cycle gives no trigger.
  - A change two cycles later triggers normally.
- Abort: `enable` low at edge 12 → `busy`=0 at edge 12, no `done`, `pass`/`fail` unchanged.
